// File: rtl/mem_arb_pkg.sv
// Shared types, constants and the byte-merge helper for the mem_arbiter
// shared-memory controller.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_id_t;

    localparam int unsigned BYTES = 4;

    // Byte i of the result comes from new_w where be[i] is set, else from old_w.
    function automatic logic [8*BYTES-1:0] merge_bytes(
        input logic [8*BYTES-1:0] old_w,
        input logic [8*BYTES-1:0] new_w,
        input logic [BYTES-1:0]   be
    );
        logic [8*BYTES-1:0] res;
        res = old_w;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: a lone requester always wins; on contention the
// port that did not win the last accepted request is granted.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_valid,
    output port_id_t   gnt
);

    port_id_t last_grant_q, last_grant_d;

    always_comb begin
        gnt_valid = |req;
        if (&req) begin
            gnt = (last_grant_q == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
        end else if (req[0]) begin
            gnt = PORT_FETCH;
        end else begin
            gnt = PORT_DATA;
        end
        last_grant_d = accept ? gnt : last_grant_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= PORT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-owner controller for the shared byte-addressable memory: arbitrates
// fetch and data ports, range-checks addresses and runs sub-word stores as RMW.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned       AWIDTH    = 32,
    parameter int unsigned       DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
    parameter logic [AWIDTH-1:0] MEM_BYTES = 32'h0010_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [AWIDTH-1:0] p0_addr,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DWIDTH-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [AWIDTH-1:0] p1_addr,
    input  logic              p1_we,
    input  logic [DWIDTH-1:0] p1_wdata,
    input  logic [BYTES-1:0]  p1_be,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DWIDTH-1:0] p1_rdata,
    output logic              p1_err,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = BASE_ADDR + MEM_BYTES - AWIDTH'(BYTES);

    state_t            state_q, state_d;
    port_id_t          port_q, port_d;
    logic              we_q, we_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [BYTES-1:0]  be_q, be_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] mem_data_q, mem_data_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              gnt_valid, accept, fault, rsp_ready_sel;
    port_id_t          gnt;
    logic [AWIDTH-1:0] sel_addr;
    logic              sel_we;
    logic [DWIDTH-1:0] sel_wdata;
    logic [BYTES-1:0]  sel_be;

    mem_arb_rr u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       ({p1_req_valid, p0_req_valid}),
        .accept    (accept),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    // Ready is gated by reset so nothing looks accepted while flops are held.
    assign accept        = rst && (state_q == IDLE) && gnt_valid;
    assign p0_req_ready  = accept && (gnt == PORT_FETCH);
    assign p1_req_ready  = accept && (gnt == PORT_DATA);
    assign rsp_ready_sel = (port_q == PORT_FETCH) ? p0_rsp_ready : p1_rsp_ready;

    assign p0_rsp_valid   = rsp_valid_q && (port_q == PORT_FETCH);
    assign p1_rsp_valid   = rsp_valid_q && (port_q == PORT_DATA);
    assign p0_rdata       = (port_q == PORT_FETCH) ? rdata_q : '0;
    assign p1_rdata       = (port_q == PORT_DATA) ? rdata_q : '0;
    assign p0_err         = err_q && (port_q == PORT_FETCH);
    assign p1_err         = err_q && (port_q == PORT_DATA);
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_o     = mem_data_q;
    assign mem_read_en_o  = rd_en_q;
    assign mem_write_en_o = wr_en_q;

    always_comb begin
        if (gnt == PORT_FETCH) begin
            sel_addr  = p0_addr;
            sel_we    = 1'b0;
            sel_wdata = '0;
            sel_be    = '1;
        end else begin
            sel_addr  = p1_addr;
            sel_we    = p1_we;
            sel_wdata = p1_wdata;
            sel_be    = p1_be;
        end
        fault = (sel_addr < BASE_ADDR) || (sel_addr > LAST_ADDR) || (sel_addr[1:0] != 2'b00);
    end

    // Memory strobes are computed one state ahead so they come straight off flops.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        rd_en_d     = rd_en_q;
        wr_en_d     = wr_en_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    port_d  = gnt;
                    we_d    = sel_we;
                    wdata_d = sel_wdata;
                    be_d    = sel_be;
                    if (fault) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                        rdata_d     = '0;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = sel_addr;
                        rd_en_d    = !sel_we || (sel_be != '1 && sel_be != '0);
                        wr_en_d    = sel_we && (sel_be == '1);
                        mem_data_d = (sel_we && sel_be == '1) ? sel_wdata : '0;
                    end
                end
            end
            ACCESS: begin
                mem_addr_d  = '0;
                mem_data_d  = '0;
                rd_en_d     = 1'b0;
                wr_en_d     = 1'b0;
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                if (!we_q) begin
                    rdata_d = mem_data_i;
                end else if (be_q != '1 && be_q != '0) begin
                    state_d     = MERGE;
                    rsp_valid_d = 1'b0;
                    mem_addr_d  = mem_addr_q;
                    wr_en_d     = 1'b1;
                    mem_data_d  = merge_bytes(mem_data_i, wdata_q, be_q);
                end
            end
            MERGE: begin
                mem_addr_d  = '0;
                mem_data_d  = '0;
                wr_en_d     = 1'b0;
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready_sel) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            port_q      <= PORT_FETCH;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-owner controller for the shared byte-addressable `memory` block (combinational read, write on rising `clk`).
- Arbitrates between port 0 (instruction fetch, read-only) and port 1 (data load/store, byte-enabled).
- Sequences sub-word stores as read-modify-write.
- Validates addresses before any access and returns one response per accepted request over a valid/ready handshake.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width; fixed at 4 bytes.
- BASE_ADDR, 32'h01000000, first valid byte address.
- MEM_BYTES, 32'h00100000, memory size in bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- p0_req_valid  in  1  fetch request.
- p0_req_ready  out  1  fetch request accepted this cycle.
- p0_addr  in  AWIDTH  fetch address.
- p0_rsp_valid  out  1  fetch response.
- p0_rsp_ready  in  1  fetch response consumed.
- p0_rdata  out  DWIDTH  fetch data.
- p0_err  out  1  fetch address fault.
- p1_req_valid  in  1  data request.
- p1_req_ready  out  1  data request accepted.
- p1_addr  in  AWIDTH  data address.
- p1_we  in  1  1=store, 0=load.
- p1_wdata  in  DWIDTH  store data.
- p1_be  in  4  byte enables, bit i = byte i (little endian).
- p1_rsp_valid  out  1  data response.
- p1_rsp_ready  in  1  data response consumed.
- p1_rdata  out  DWIDTH  load data.
- p1_err  out  1  data address fault.
- mem_addr_o  out  AWIDTH  to memory addr_i.
- mem_data_o  out  DWIDTH  to memory data_i.
- mem_read_en_o  out  1  to memory read_en_i.
- mem_write_en_o  out  1  to memory write_en_i.
- mem_data_i  in  DWIDTH  from memory data_o.

Behaviour:
- Reset (rst=0, async): state=IDLE, last_grant=1, so port 0 wins first.
  - All outputs 0.
  - Any in-flight request is dropped; no write issues afterwards.
- One outstanding request total. req_ready is asserted only in IDLE, for the granted port, combinationally from req_valid.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the port not equal to last_grant, then update last_grant.
- On accept, latch port id, addr, we, wdata, be.
- Fault check at accept: addr < BASE_ADDR, addr > BASE_ADDR+MEM_BYTES-4, or addr[1:0]!=0.
  - Go to RESP with err=1, rdata=0.
  - Memory enables stay 0.
- FSM states: IDLE, ACCESS, MERGE, RESP.
- ACCESS (mem_addr_o = latched addr):
  - Load/fetch, or store with be!=4'hF: mem_read_en_o=1; capture mem_data_i into rdata.
  - Load/fetch -> RESP.
  - Partial store -> MERGE.
  - Store with be==4'hF: mem_write_en_o=1, mem_data_o=wdata -> RESP.
  - Store with be==0: treated as no-op -> RESP, no write.
- MERGE: mem_write_en_o=1; mem_data_o byte i = be[i] ? wdata byte i : rdata byte i -> RESP.
- RESP:
  - Granted port's rsp_valid=1 with rdata and err held stable until rsp_ready.
  - On rsp_ready -> IDLE.
  - rdata is 0 for stores.
  - No new request is accepted in the same cycle as rsp_ready.
- Latency (accept at cycle 0):
  - Load or full store: rsp_valid at cycle 2.
  - Partial store: cycle 3.
  - Fault: cycle 1.
- Memory enables, mem_addr_o and mem_data_o are 0 outside ACCESS/MERGE.
- Enables are never both 1 in the same cycle.
- Requesters must hold req signals stable while req_valid && !req_ready.

Decomposition:
- mem_arb_pkg:
  - state_t enum {IDLE, ACCESS, MERGE, RESP}.
  - port_id_t (1 bit): PORT_FETCH=0, PORT_DATA=1.
  - Byte-count constant 4.
- Sub-module mem_arb_rr: 2-way round-robin grant with last_grant register and update-on-accept input.

Test Plan:
- Reset, then p0 read at 0x01000000 with memory word 0xDEADBEEF -> p0_req_ready cycle 0, p0_rsp_valid cycle 2, p0_rdata=0xDEADBEEF, p0_err=0.
- p1 store at 0x01000010, wdata=0x11223344, be=4'hF; then load same address -> single write pulse; load returns 0x11223344 at cycle 2.
- Word 0xAABBCCDD at 0x01000020; p1 store wdata=0x00000055, be=4'b0001 -> read pulse then write pulse; rsp at cycle 3; reload returns 0xAABBCC55.
- Both ports valid every cycle, responses accepted immediately -> grants alternate p0,p1,p0,p1 starting with p0 after reset.
- p1 load at 0x00FFFFFC, 0x01100000, and 0x01000002 -> each p1_err=1, rdata=0, rsp at cycle 1, mem enables never asserted.
- Partial store accepted, rst pulsed low in MERGE cycle -> mem_write_en_o=0 immediately, memory word unchanged, all rsp_valid=0, next grant is p0.
